bram_port_arbiter: RTL

Two-requester arbiter that shares one single-port block RAM (1-bit write enable, 16 × 16-bit) between two independent clients, e.g. a pattern writer and a display reader. Each client sees a valid/grant request port and its own read-return channel. The block drives the RAM's ena/wea/addra/dina pins and routes douta back to the client that issued each read. It sits between the client FSMs and the RAM instance.

---
 rtl/bram_port_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bram_port_arbiter.sv
// Two-client arbiter for one single-port block RAM: fair grant on contention,
// registered RAM pins, and a tag pipeline that routes read data back to its issuer.
//
// lg state | meaning
// ---------+----------------------------------------------
// LG_A     | A was granted last; B wins the next contention
// LG_B     | B was granted last (reset); A wins the next contention
module bram_port_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk_g,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              mem_ena,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    input  logic [DATA_W-1:0] mem_douta,
    output logic [7:0]        conflict_cnt
);

    typedef enum logic {
        LG_A = 1'b0,
        LG_B = 1'b1
    } lg_t;

    localparam int DEPTH = RD_LAT + 1;

    lg_t               lg_q;
    lg_t               lg_d;
    logic              xfer;
    logic              sel_b;
    logic              x_we;
    logic [ADDR_W-1:0] x_addr;
    logic [DATA_W-1:0] x_wdata;
    logic [DEPTH-1:0]  tag_v;
    logic [DEPTH-1:0]  tag_o;
    logic              tail_v;
    logic              tail_o;

    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            lg_q <= LG_B;
        end else begin
            lg_q <= lg_d;
        end
    end

    // Grant is forced low during reset so no transfer can be seen while rst_n is low.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        lg_d  = lg_q;
        if (rst_n) begin
            if (req_a && (!req_b || lg_q == LG_B)) begin
                gnt_a = 1'b1;
                lg_d  = LG_A;
            end else if (req_b) begin
                gnt_b = 1'b1;
                lg_d  = LG_B;
            end
        end
    end

    assign xfer    = gnt_a | gnt_b;
    assign sel_b   = gnt_b;
    assign x_we    = sel_b ? we_b    : we_a;
    assign x_addr  = sel_b ? addr_b  : addr_a;
    assign x_wdata = sel_b ? wdata_b : wdata_a;

    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            mem_ena   <= 1'b0;
            mem_wea   <= 1'b0;
            mem_addra <= '0;
            mem_dina  <= '0;
        end else if (xfer) begin
            mem_ena   <= 1'b1;
            mem_wea   <= x_we;
            mem_addra <= x_addr;
            mem_dina  <= x_wdata;
        end else begin
            mem_ena   <= 1'b0;
            mem_wea   <= 1'b0;
        end
    end

    // Tag reaching the tail lines up with douta being valid for that read.
    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            tag_o <= '0;
        end else begin
            tag_v <= {tag_v[DEPTH-2:0], xfer & ~x_we};
            tag_o <= {tag_o[DEPTH-2:0], sel_b};
        end
    end

    assign tail_v = tag_v[DEPTH-1];
    assign tail_o = tag_o[DEPTH-1];

    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            rdata_a  <= '0;
            rdata_b  <= '0;
        end else begin
            rvalid_a <= tail_v & ~tail_o;
            rvalid_b <= tail_v & tail_o;
            if (tail_v && !tail_o) begin
                rdata_a <= mem_douta;
            end
            if (tail_v && tail_o) begin
                rdata_b <= mem_douta;
            end
        end
    end

    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= 8'd0;
        end else if (req_a && req_b && conflict_cnt != 8'hFF) begin
            conflict_cnt <= conflict_cnt + 8'd1;
        end
    end

endmodule
